// File: rtl/bp_mem_arbiter.sv
// Shares one bp_mem command/response port pair among num_req_p requesters.
// Build option: define BP_MEM_ARB_RR_EN for round-robin grant, otherwise fixed priority (lowest index wins).
module bp_mem_arbiter #(
  parameter int num_req_p     = 2,
  parameter int cmd_width_p   = 8,
  parameter int resp_width_p  = 8,
  parameter int outstanding_p = 4,
  localparam int idx_w        = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_w        = $clog2(outstanding_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]           req_v_i,
  output logic [num_req_p-1:0]           req_yumi_o,

  output logic [cmd_width_p-1:0]         mem_cmd_o,
  output logic                           mem_cmd_v_o,
  input  logic                           mem_cmd_yumi_i,

  input  logic [resp_width_p-1:0]        mem_resp_i,
  input  logic                           mem_resp_v_i,
  output logic                           mem_resp_ready_o,

  output logic [resp_width_p-1:0]        resp_o,
  output logic [num_req_p-1:0]           resp_v_o,
  input  logic [num_req_p-1:0]           resp_ready_i,

  output logic [cnt_w-1:0]               outstanding_o,
  output logic                           err_o
);

  // Handshakes: the command channel is valid/yumi (yumi only while valid, the
  // transfer happens on that edge); the response channel is valid/ready
  // (transfer on any edge where both are high; valid never waits on ready).

  localparam int ptr_w = $clog2(outstanding_p);

  logic [idx_w-1:0] tags_q [outstanding_p];
  logic [ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0] count_q;
  logic             err_q;

  logic             full, empty;
  logic             any_v;
  logic [idx_w-1:0] winner;
  logic [idx_w-1:0] owner;
  logic             push, pop;

  assign full  = (count_q == cnt_w'(outstanding_p));
  assign empty = (count_q == '0);
  assign any_v = |req_v_i;

`ifdef BP_MEM_ARB_RR_EN
  logic [idx_w-1:0] last_q;
  int               cand;
  logic             found;

  // Search begins just past the last pushed winner, wrapping around.
  always_comb begin
    winner = '0;
    cand   = 0;
    found  = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      cand = (int'(last_q) + 1 + k) % num_req_p;
      if (!found && req_v_i[cand]) begin
        winner = idx_w'(cand);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= idx_w'(num_req_p - 1);
    end else if (push) begin
      last_q <= winner;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (req_v_i[i]) winner = idx_w'(i);
    end
  end
`endif

  // Full uses registered occupancy so yumi never feeds back into valid.
  assign mem_cmd_v_o = any_v & ~full;
  assign mem_cmd_o   = any_v ? req_cmd_i[int'(winner)*cmd_width_p +: cmd_width_p]
                             : '0;
  assign push        = mem_cmd_v_o & mem_cmd_yumi_i;

  always_comb begin
    req_yumi_o         = '0;
    req_yumi_o[winner] = push;
  end

  assign owner            = tags_q[rd_ptr_q];
  assign mem_resp_ready_o = ~empty & resp_ready_i[owner];
  assign pop              = mem_resp_v_i & mem_resp_ready_o;
  assign resp_o           = mem_resp_i;

  always_comb begin
    resp_v_o        = '0;
    resp_v_o[owner] = mem_resp_v_i & ~empty;
  end

  // Tag storage needs no reset: entries are only read while occupancy > 0.
  always_ff @(posedge clk_i) begin
    if (push) tags_q[wr_ptr_q] <= winner;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A response with no recorded owner can only be a protocol error.
      if (mem_resp_v_i & empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Self-checking bench for bp_mem_arbiter: queue-based reference model plus directed scenarios.
module tb_bp_mem_arbiter;

  localparam int N   = 2;
  localparam int CW  = 8;
  localparam int RW  = 8;
  localparam int OUT = 4;
  localparam int CNTW = $clog2(OUT + 1);

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_n_i;

  logic [N*CW-1:0] req_cmd_i;
  logic [N-1:0]    req_v_i;
  logic [N-1:0]    req_yumi_o;
  logic [CW-1:0]   mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_yumi_i;
  logic [RW-1:0]   mem_resp_i;
  logic            mem_resp_v_i;
  logic            mem_resp_ready_o;
  logic [RW-1:0]   resp_o;
  logic [N-1:0]    resp_v_o;
  logic [N-1:0]    resp_ready_i;
  logic [CNTW-1:0] outstanding_o;
  logic            err_o;

  bp_mem_arbiter #(
    .num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW), .outstanding_p(OUT)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_cmd_i(req_cmd_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // ---------------- reference model ----------------
  int model_q[$];   // owners of commands in flight, oldest first
  bit model_err;
  int model_last;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // staged inputs, applied at the next falling edge
  logic [N*CW-1:0] s_cmd;
  logic [N-1:0]    s_req_v;
  logic            s_yumi;
  logic            s_resp_v;
  logic [RW-1:0]   s_resp;
  logic [N-1:0]    s_ready;

  task automatic model_reset();
    model_q.delete();
    model_err  = 1'b0;
    model_last = N - 1;
  endtask

  function automatic int model_winner(input logic [N-1:0] v);
    int best   = -1;
    int best_d = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef BP_MEM_ARB_RR_EN
        int d = (i - model_last - 1 + 2 * N) % N;
`else
        int d = i;
`endif
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic stage_idle();
    s_cmd    = '0;
    s_req_v  = '0;
    s_yumi   = 1'b0;
    s_resp_v = 1'b0;
    s_resp   = '0;
    s_ready  = '0;
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic cycle();
    int        sz, w, owner;
    bit        full, empty, cmd_v, exp_ready;
    logic [N-1:0] exp_yumi, exp_resp_v;
    @(negedge clk_i);
    req_cmd_i    = s_cmd;
    req_v_i      = s_req_v;
    mem_resp_v_i = s_resp_v;
    mem_resp_i   = s_resp;
    resp_ready_i = s_ready;

    sz    = model_q.size();
    full  = (sz == OUT);
    empty = (sz == 0);
    w     = model_winner(s_req_v);
    cmd_v = (w >= 0) && !full;
    mem_cmd_yumi_i = s_yumi & cmd_v;
    owner = empty ? 0 : model_q[0];
    exp_ready  = !empty && s_ready[owner];
    exp_yumi   = (cmd_v && s_yumi) ? N'(1 << w) : '0;
    exp_resp_v = (!empty && s_resp_v) ? N'(1 << owner) : '0;
    #1;
    chk("req_yumi", req_yumi_o, exp_yumi);
    chk("mem_cmd_v", mem_cmd_v_o, cmd_v);
    if (cmd_v) chk("mem_cmd", mem_cmd_o, s_cmd[w*CW +: CW]);
    chk("resp_v", resp_v_o, exp_resp_v);
    chk("mem_resp_ready", mem_resp_ready_o, exp_ready);
    chk("resp_data", resp_o, s_resp);
    chk("outstanding", outstanding_o, sz);
    chk("err", err_o, model_err);

    if (reset_n_i) begin
      if (s_resp_v && empty) model_err = 1'b1;
      if (s_resp_v && exp_ready) void'(model_q.pop_front());
      if (cmd_v && s_yumi) begin
        model_q.push_back(w);
        model_last = w;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && model_q.size() > 0; i++) begin
      stage_idle();
      s_resp_v = 1'b1;
      s_ready  = '1;
      s_resp   = RW'($urandom);
      cycle();
    end
    stage_idle();
    cycle();
    chk("drain_outstanding", outstanding_o, 0);
  endtask

  task automatic random_phase(input int n, input bit allow_spurious);
    for (int i = 0; i < n; i++) begin
      s_cmd    = (N*CW)'({$urandom, $urandom});
      s_req_v  = N'($urandom_range(0, (1 << N) - 1));
      s_yumi   = 1'($urandom_range(0, 1));
      s_resp_v = 1'($urandom_range(0, 1)) && (allow_spurious || model_q.size() > 0);
      s_resp   = RW'($urandom);
      s_ready  = N'($urandom_range(0, (1 << N) - 1));
      cycle();
    end
  endtask

  logic [N-1:0] contention_exp [4];

  initial begin
`ifdef BP_MEM_ARB_RR_EN
    contention_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    contention_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    reset_n_i = 1'b0;
    req_cmd_i = '0; req_v_i = '0; mem_cmd_yumi_i = 1'b0;
    mem_resp_i = '0; mem_resp_v_i = 1'b0; resp_ready_i = '0;
    model_reset();
    stage_idle();
    cycle();
    cycle();
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cmd_v", mem_cmd_v_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_yumi", req_yumi_o, 0);
    reset_n_i = 1'b1;

    random_phase(300, 1'b0);
    drain();

    // single request from requester 1
    stage_idle();
    s_req_v = 2'b10; s_cmd = {8'hA5, 8'h3C}; s_yumi = 1'b1;
    cycle();
    chk("single_yumi", req_yumi_o, 2'b10);
    chk("single_cmd", mem_cmd_o, 8'hA5);
    stage_idle();
    cycle();
    chk("single_outstanding", outstanding_o, 1);
    stage_idle();
    s_resp_v = 1'b1; s_ready = 2'b11; s_resp = 8'h5A;
    cycle();
    chk("single_resp_v", resp_v_o, 2'b10);
    chk("single_resp_ready", mem_resp_ready_o, 1);
    chk("single_resp_data", resp_o, 8'h5A);
    stage_idle();
    cycle();
    chk("single_done", outstanding_o, 0);

    // contention: four consecutive yumi cycles
    for (int k = 0; k < 4; k++) begin
      stage_idle();
      s_req_v = 2'b11; s_cmd = {8'h11, 8'h22}; s_yumi = 1'b1;
      cycle();
      chk("contention_grant", req_yumi_o, contention_exp[k]);
    end

    // full: no grant, even in the cycle a response pops
    stage_idle();
    s_req_v = 2'b11; s_yumi = 1'b1;
    cycle();
    chk("full_cmd_v", mem_cmd_v_o, 0);
    chk("full_outstanding", outstanding_o, 4);
    chk("full_yumi", req_yumi_o, 0);
    s_resp_v = 1'b1; s_ready = 2'b11;
    cycle();
    chk("full_pop_cmd_v", mem_cmd_v_o, 0);
    chk("full_pop_ready", mem_resp_ready_o, 1);
    stage_idle();
    s_req_v = 2'b11;
    cycle();
    chk("after_pop_cmd_v", mem_cmd_v_o, 1);
    chk("after_pop_outstanding", outstanding_o, 3);
    drain();

    // owner backpressure: head owner 0, then owner 1
    stage_idle();
    s_req_v = 2'b01; s_yumi = 1'b1;
    cycle();
    s_req_v = 2'b10;
    cycle();
    for (int k = 0; k < 3; k++) begin
      stage_idle();
      s_resp_v = 1'b1; s_ready = 2'b10;
      cycle();
      chk("bp_ready", mem_resp_ready_o, 0);
      chk("bp_outstanding", outstanding_o, 2);
      chk("bp_resp_v", resp_v_o, 2'b01);
    end
    s_ready = 2'b11;
    cycle();
    chk("bp_release_ready", mem_resp_ready_o, 1);
    cycle();
    chk("bp_next_owner", resp_v_o, 2'b10);
    chk("bp_next_ready", mem_resp_ready_o, 1);
    chk("bp_next_outstanding", outstanding_o, 1);
    stage_idle();
    cycle();
    chk("bp_done", outstanding_o, 0);

    // spurious response while empty
    stage_idle();
    s_resp_v = 1'b1; s_ready = 2'b11;
    cycle();
    chk("spur_ready", mem_resp_ready_o, 0);
    chk("spur_resp_v", resp_v_o, 0);
    chk("spur_err_before", err_o, 0);
    stage_idle();
    cycle();
    chk("spur_err_set", err_o, 1);
    cycle();
    chk("spur_err_held", err_o, 1);

    // asynchronous reset with three commands in flight
    for (int k = 0; k < 3; k++) begin
      stage_idle();
      s_req_v = 2'b01; s_yumi = 1'b1;
      cycle();
    end
    stage_idle();
    cycle();
    chk("mid_outstanding", outstanding_o, 3);
    #2 reset_n_i = 1'b0;
    model_reset();
    #1;
    chk("async_rst_outstanding", outstanding_o, 0);
    chk("async_rst_err", err_o, 0);
    chk("async_rst_cmd_v", mem_cmd_v_o, 0);
    stage_idle();
    cycle();
    cycle();
    reset_n_i = 1'b1;
    stage_idle();
    s_req_v = 2'b11; s_yumi = 1'b1;
    cycle();
    chk("post_rst_grant", req_yumi_o, 2'b01);
    drain();

    random_phase(400, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
